// File: rtl/decompression_dispatcher.sv
// Decompression dispatcher: splits a framed compressed stream into chunks,
// hands chunks round-robin to N_CORES decompression cores, and reassembles
// the decompressed chunks in original order using an order FIFO.
//
// Input FSM states:
//   state   | meaning
//   ST_HDR  | waiting for a chunk header (uncom_size, com_size)
//   ST_BODY | forwarding body beats of the current chunk to core_in[wr_ptr]
module decompression_dispatcher #(
   parameter int N_CORES   = 4,
   parameter int DATA_BITS = 512,
   parameter int SIZE_W    = 16,
   parameter int ORD_DEPTH = 2*N_CORES
) (
   input  logic                                  aclk,
   input  logic                                  aresetn,
   input  logic [DATA_BITS-1:0]                  i_data_tdata,
   input  logic [DATA_BITS/8-1:0]                i_data_tkeep,
   input  logic                                  i_data_tlast,
   input  logic                                  i_data_tvalid,
   output logic                                  i_data_tready,
   output logic [N_CORES-1:0][DATA_BITS-1:0]     core_in_tdata,
   output logic [N_CORES-1:0][DATA_BITS/8-1:0]   core_in_tkeep,
   output logic [N_CORES-1:0]                    core_in_tlast,
   output logic [N_CORES-1:0]                    core_in_tvalid,
   input  logic [N_CORES-1:0]                    core_in_tready,
   input  logic [N_CORES-1:0][DATA_BITS-1:0]     core_out_tdata,
   input  logic [N_CORES-1:0][DATA_BITS/8-1:0]   core_out_tkeep,
   input  logic [N_CORES-1:0]                    core_out_tlast,
   input  logic [N_CORES-1:0]                    core_out_tvalid,
   output logic [N_CORES-1:0]                    core_out_tready,
   output logic [DATA_BITS-1:0]                  o_data_tdata,
   output logic [DATA_BITS/8-1:0]                o_data_tkeep,
   output logic                                  o_data_tlast,
   output logic                                  o_data_tvalid,
   input  logic                                  o_data_tready,
   output logic                                  err_size,
   output logic                                  err_zero
);

   localparam int KEEP_BITS = DATA_BITS/8;
   localparam int PTR_W     = (N_CORES > 1) ? $clog2(N_CORES) : 1;
   localparam int ORD_AW    = (ORD_DEPTH > 1) ? $clog2(ORD_DEPTH) : 1;
   localparam int ORD_CW    = $clog2(ORD_DEPTH+1);
   localparam int POP_W     = $clog2(KEEP_BITS+1);

   typedef enum logic {ST_HDR, ST_BODY} state_t;

   state_t              state_q, state_d;
   logic [SIZE_W-1:0]   beat_cnt;
   logic [PTR_W-1:0]    wr_ptr, rd_ptr;
   logic [ORD_AW-1:0]   ord_wr, ord_rd, cur_idx;
   logic [ORD_CW-1:0]   ord_cnt;
   logic [SIZE_W-1:0]   ord_size [ORD_DEPTH];
   logic                ord_last [ORD_DEPTH];
   logic [SIZE_W:0]     byte_cnt, byte_sum;
   logic [POP_W-1:0]    keep_cnt;

   logic [SIZE_W-1:0]   hdr_com, hdr_uncom, hdr_beats;
   logic [SIZE_W:0]     com_round;
   logic                ord_full, ord_empty;
   logic                hdr_acc, body_acc, body_end, push, pop, patch;
   logic                out_hs, out_end, head_last;

   assign hdr_com   = i_data_tdata[SIZE_W-1:0];
   assign hdr_uncom = i_data_tdata[2*SIZE_W-1:SIZE_W];
   // Body beats needed to carry com_size bytes, rounded up to whole beats.
   assign com_round = {1'b0, hdr_com} + (SIZE_W+1)'(KEEP_BITS-1);
   assign hdr_beats = SIZE_W'(com_round / (SIZE_W+1)'(KEEP_BITS));

   assign ord_full  = (ord_cnt == ORD_CW'(ORD_DEPTH));
   assign ord_empty = (ord_cnt == '0);

   assign core_in_tdata = {N_CORES{i_data_tdata}};
   assign core_in_tkeep = {N_CORES{i_data_tkeep}};

   // Input FSM state register.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) state_q <= ST_HDR;
      else          state_q <= state_d;
   end

   // Input FSM next state, core_in routing and handshake strobes.
   always_comb begin
      state_d        = state_q;
      i_data_tready  = 1'b0;
      core_in_tvalid = '0;
      core_in_tlast  = '0;
      hdr_acc        = 1'b0;
      body_acc       = 1'b0;
      body_end       = 1'b0;
      unique case (state_q)
         ST_HDR: begin
            // Gated by reset because the HDR state itself is the reset state.
            i_data_tready = aresetn & ~ord_full;
            if (i_data_tvalid && aresetn && !ord_full) begin
               hdr_acc = 1'b1;
               if (hdr_com != '0) state_d = ST_BODY;
            end
         end
         ST_BODY: begin
            core_in_tvalid[wr_ptr] = i_data_tvalid;
            core_in_tlast[wr_ptr]  = (beat_cnt == SIZE_W'(1));
            i_data_tready          = core_in_tready[wr_ptr];
            if (i_data_tvalid && core_in_tready[wr_ptr]) begin
               body_acc = 1'b1;
               if (beat_cnt == SIZE_W'(1)) begin
                  body_end = 1'b1;
                  state_d  = ST_HDR;
               end
            end
         end
      endcase
   end

   assign push  = hdr_acc & (hdr_com != '0);
   assign patch = body_end & i_data_tlast;

   // Output side: serve only the core that owns the oldest outstanding chunk.
   always_comb begin
      core_out_tready         = '0;
      core_out_tready[rd_ptr] = ~ord_empty & o_data_tready;
   end

   assign o_data_tvalid = ~ord_empty & core_out_tvalid[rd_ptr];
   assign o_data_tdata  = core_out_tdata[rd_ptr];
   assign o_data_tkeep  = core_out_tkeep[rd_ptr];
   assign out_hs        = o_data_tvalid & o_data_tready;
   assign out_end       = out_hs & core_out_tlast[rd_ptr];
   assign pop           = out_end;
   // Bypass a last-flag patch landing on the head entry in the same cycle.
   assign head_last     = ord_last[ord_rd] | (patch && (cur_idx == ord_rd));
   assign o_data_tlast  = ~ord_empty & core_out_tlast[rd_ptr] & head_last;

   // Byte count of the current output beat.
   always_comb begin
      keep_cnt = '0;
      for (int i = 0; i < KEEP_BITS; i++)
         keep_cnt = keep_cnt + {{(POP_W-1){1'b0}}, core_out_tkeep[rd_ptr][i]};
   end

   assign byte_sum = byte_cnt + (SIZE_W+1)'(keep_cnt);

   // Order FIFO storage: new entries start as not-last, patched on the final body beat.
   always_ff @(posedge aclk) begin
      if (push) begin
         ord_size[ord_wr] <= hdr_uncom;
         ord_last[ord_wr] <= 1'b0;
      end else if (patch) begin
         ord_last[cur_idx] <= 1'b1;
      end
   end

   // Beat counter, dispatch pointer, order FIFO pointers and zero-length flag.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         beat_cnt <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         ord_wr   <= '0;
         ord_rd   <= '0;
         ord_cnt  <= '0;
         cur_idx  <= '0;
         err_zero <= 1'b0;
      end else begin
         if (hdr_acc)       beat_cnt <= hdr_beats;
         else if (body_acc) beat_cnt <= beat_cnt - SIZE_W'(1);
         if (hdr_acc && hdr_com == '0) err_zero <= 1'b1;
         if (push) begin
            cur_idx <= ord_wr;
            ord_wr  <= (ord_wr == ORD_AW'(ORD_DEPTH-1)) ? '0 : ord_wr + ORD_AW'(1);
         end
         if (body_end) wr_ptr <= (wr_ptr == PTR_W'(N_CORES-1)) ? '0 : wr_ptr + PTR_W'(1);
         if (pop) begin
            ord_rd <= (ord_rd == ORD_AW'(ORD_DEPTH-1)) ? '0 : ord_rd + ORD_AW'(1);
            rd_ptr <= (rd_ptr == PTR_W'(N_CORES-1)) ? '0 : rd_ptr + PTR_W'(1);
         end
         if (push && !pop)      ord_cnt <= ord_cnt + ORD_CW'(1);
         else if (pop && !push) ord_cnt <= ord_cnt - ORD_CW'(1);
      end
   end

   // Per-chunk output byte accumulation and sticky size-mismatch flag.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         byte_cnt <= '0;
         err_size <= 1'b0;
      end else if (out_end) begin
         byte_cnt <= '0;
         if (byte_sum != {1'b0, ord_size[ord_rd]}) err_size <= 1'b1;
      end else if (out_hs) begin
         byte_cnt <= byte_sum;
      end
   end

endmodule

// File: tb/tb_decompression_dispatcher.sv
// Directed bench for decompression_dispatcher at default parameters
// (4 cores, 64-byte beats, 16-bit size fields, 8-entry order FIFO).
module tb_decompression_dispatcher;

   localparam int NC = 4;
   localparam int DB = 512;
   localparam int KB = DB/8;

   logic                    aclk = 1'b0;
   logic                    aresetn;
   logic [DB-1:0]           i_data_tdata;
   logic [KB-1:0]           i_data_tkeep;
   logic                    i_data_tlast, i_data_tvalid, i_data_tready;
   logic [NC-1:0][DB-1:0]   core_in_tdata;
   logic [NC-1:0][KB-1:0]   core_in_tkeep;
   logic [NC-1:0]           core_in_tlast, core_in_tvalid, core_in_tready;
   logic [NC-1:0][DB-1:0]   core_out_tdata;
   logic [NC-1:0][KB-1:0]   core_out_tkeep;
   logic [NC-1:0]           core_out_tlast, core_out_tvalid, core_out_tready;
   logic [DB-1:0]           o_data_tdata;
   logic [KB-1:0]           o_data_tkeep;
   logic                    o_data_tlast, o_data_tvalid, o_data_tready;
   logic                    err_size, err_zero;

   int checks = 0;
   int errors = 0;

   int          in_core_q[$];
   int          in_beats_q[$];
   int          beat_run[NC];
   int          in_hs_total;
   bit          multi_valid;
   logic [7:0]  out_tag_q[$];
   logic        out_last_q[$];

   decompression_dispatcher dut (
      .aclk(aclk), .aresetn(aresetn),
      .i_data_tdata(i_data_tdata), .i_data_tkeep(i_data_tkeep), .i_data_tlast(i_data_tlast),
      .i_data_tvalid(i_data_tvalid), .i_data_tready(i_data_tready),
      .core_in_tdata(core_in_tdata), .core_in_tkeep(core_in_tkeep), .core_in_tlast(core_in_tlast),
      .core_in_tvalid(core_in_tvalid), .core_in_tready(core_in_tready),
      .core_out_tdata(core_out_tdata), .core_out_tkeep(core_out_tkeep), .core_out_tlast(core_out_tlast),
      .core_out_tvalid(core_out_tvalid), .core_out_tready(core_out_tready),
      .o_data_tdata(o_data_tdata), .o_data_tkeep(o_data_tkeep), .o_data_tlast(o_data_tlast),
      .o_data_tvalid(o_data_tvalid), .o_data_tready(o_data_tready),
      .err_size(err_size), .err_zero(err_zero)
   );

   always #5 aclk = ~aclk;

   // Records per-core dispatched chunks and the reassembled output stream.
   initial forever begin
      @(posedge aclk);
      if (aresetn) begin
         if ($countones(core_in_tvalid) > 1) multi_valid = 1'b1;
         for (int c = 0; c < NC; c++) begin
            if (core_in_tvalid[c] && core_in_tready[c]) begin
               in_hs_total++;
               beat_run[c]++;
               if (core_in_tlast[c]) begin
                  in_core_q.push_back(c);
                  in_beats_q.push_back(beat_run[c]);
                  beat_run[c] = 0;
               end
            end
         end
         if (o_data_tvalid && o_data_tready) begin
            out_tag_q.push_back(o_data_tdata[7:0]);
            out_last_q.push_back(o_data_tlast);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic clear_inputs();
      i_data_tdata    = '0;
      i_data_tkeep    = '1;
      i_data_tlast    = 1'b0;
      i_data_tvalid   = 1'b0;
      core_in_tready  = '1;
      core_out_tdata  = '0;
      core_out_tkeep  = '0;
      core_out_tlast  = '0;
      core_out_tvalid = '0;
      o_data_tready   = 1'b1;
   endtask

   task automatic clear_logs();
      in_core_q.delete();
      in_beats_q.delete();
      out_tag_q.delete();
      out_last_q.delete();
      for (int c = 0; c < NC; c++) beat_run[c] = 0;
      in_hs_total = 0;
      multi_valid = 1'b0;
   endtask

   task automatic do_reset();
      aresetn = 1'b0;
      clear_inputs();
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      aresetn = 1'b1;
      clear_logs();
      @(posedge aclk);
      #1;
   endtask

   task automatic send_hdr(input logic [15:0] uncom, input logic [15:0] com);
      int n = 0;
      i_data_tdata        = '0;
      i_data_tdata[31:0]  = {uncom, com};
      i_data_tlast        = 1'b0;
      i_data_tvalid       = 1'b1;
      #1;
      while (!i_data_tready && n < 50) begin
         @(posedge aclk); #1; n++;
      end
      checks++;
      if (i_data_tready !== 1'b1) begin
         errors++;
         $display("FAIL hdr_accept: i_data_tready=%0b required 1 within 50 cycles", i_data_tready);
      end
      @(posedge aclk); #1;
      i_data_tvalid = 1'b0;
   endtask

   task automatic send_body(input int nbeats, input bit last);
      for (int b = 0; b < nbeats; b++) begin
         int n = 0;
         i_data_tdata  = DB'(b + 1);
         i_data_tlast  = last && (b == nbeats - 1);
         i_data_tvalid = 1'b1;
         #1;
         while (!i_data_tready && n < 50) begin
            @(posedge aclk); #1; n++;
         end
         checks++;
         if (i_data_tready !== 1'b1) begin
            errors++;
            $display("FAIL body_accept: i_data_tready=%0b required 1 within 50 cycles", i_data_tready);
         end
         @(posedge aclk); #1;
      end
      i_data_tvalid = 1'b0;
      i_data_tlast  = 1'b0;
   endtask

   task automatic send_chunk(input logic [15:0] uncom, input logic [15:0] com,
                             input int nbeats, input bit last);
      send_hdr(uncom, com);
      send_body(nbeats, last);
   endtask

   task automatic core_send(input int c, input int nbeats, input int last_bytes, input logic [7:0] tag);
      logic [KB-1:0] lk;
      lk = '0;
      for (int i = 0; i < last_bytes; i++) lk[i] = 1'b1;
      for (int b = 0; b < nbeats; b++) begin
         int n = 0;
         core_out_tdata[c]  = DB'(tag + 8'(b));
         core_out_tkeep[c]  = (b == nbeats - 1) ? lk : '1;
         core_out_tlast[c]  = (b == nbeats - 1);
         core_out_tvalid[c] = 1'b1;
         #1;
         while (!core_out_tready[c] && n < 50) begin
            @(posedge aclk); #1; n++;
         end
         checks++;
         if (core_out_tready[c] !== 1'b1) begin
            errors++;
            $display("FAIL core_out_ready: core %0d tready=%0b required 1 within 50 cycles", c, core_out_tready[c]);
         end
         @(posedge aclk); #1;
      end
      core_out_tvalid[c] = 1'b0;
      core_out_tlast[c]  = 1'b0;
   endtask

   task automatic test_reset();
      aresetn = 1'b0;
      clear_inputs();
      clear_logs();
      i_data_tvalid      = 1'b1;
      core_out_tvalid[0] = 1'b1;
      repeat (2) @(posedge aclk);
      #1;
      checks++;
      if (i_data_tready !== 1'b0) begin errors++; $display("FAIL rst_i_tready: got %0b required 0", i_data_tready); end
      checks++;
      if (core_in_tvalid !== '0) begin errors++; $display("FAIL rst_core_in_tvalid: got %b required 0000", core_in_tvalid); end
      checks++;
      if (core_out_tready !== '0) begin errors++; $display("FAIL rst_core_out_tready: got %b required 0000", core_out_tready); end
      checks++;
      if (o_data_tvalid !== 1'b0) begin errors++; $display("FAIL rst_o_tvalid: got %0b required 0", o_data_tvalid); end
      i_data_tvalid = 1'b0;
      @(negedge aclk);
      aresetn = 1'b1;
      @(posedge aclk); #1;
      checks++;
      if ({err_size, err_zero} !== 2'b00) begin errors++; $display("FAIL rst_errs: got %b required 00", {err_size, err_zero}); end
      checks++;
      if (i_data_tready !== 1'b1) begin errors++; $display("FAIL post_rst_i_tready: got %0b required 1", i_data_tready); end
      checks++;
      if (o_data_tvalid !== 1'b0 || core_out_tready !== '0) begin
         errors++;
         $display("FAIL post_rst_out_idle: o_tvalid=%0b core_out_tready=%b required 0/0000", o_data_tvalid, core_out_tready);
      end
      core_out_tvalid[0] = 1'b0;
   endtask

   task automatic test_round_robin();
      int exp_core[6] = '{0, 1, 2, 3, 0, 1};
      do_reset();
      for (int k = 0; k < 6; k++) send_chunk(16'd128, 16'd100, 2, 1'b0);
      checks++;
      if (in_core_q.size() !== 6) begin errors++; $display("FAIL rr_count: got %0d chunks required 6", in_core_q.size()); end
      for (int k = 0; k < 6; k++) begin
         int got_c, got_b;
         got_c = (k < in_core_q.size()) ? in_core_q[k] : -1;
         got_b = (k < in_beats_q.size()) ? in_beats_q[k] : -1;
         checks++;
         if (got_c !== exp_core[k]) begin errors++; $display("FAIL rr_core[%0d]: got %0d required %0d", k, got_c, exp_core[k]); end
         checks++;
         if (got_b !== 2) begin errors++; $display("FAIL rr_beats[%0d]: got %0d required 2", k, got_b); end
      end
      checks++;
      if (multi_valid !== 1'b0) begin errors++; $display("FAIL rr_one_hot: multiple core_in tvalid seen"); end
   endtask

   task automatic test_reorder();
      logic [7:0] exp_tag[3]  = '{8'hA0, 8'hA1, 8'h11};
      logic       exp_last[3] = '{1'b0, 1'b0, 1'b1};
      int n = 0;
      do_reset();
      send_chunk(16'd128, 16'd100, 2, 1'b0);
      send_chunk(16'd64, 16'd50, 1, 1'b1);
      core_out_tdata[1]  = DB'(8'h11);
      core_out_tkeep[1]  = '1;
      core_out_tlast[1]  = 1'b1;
      core_out_tvalid[1] = 1'b1;
      repeat (3) @(posedge aclk);
      #1;
      checks++;
      if (o_data_tvalid !== 1'b0 || core_out_tready[1] !== 1'b0) begin
         errors++;
         $display("FAIL reorder_hold: o_tvalid=%0b core1_tready=%0b required 0/0", o_data_tvalid, core_out_tready[1]);
      end
      core_send(0, 2, 64, 8'hA0);
      while (!core_out_tready[1] && n < 50) begin
         @(posedge aclk); #1; n++;
      end
      checks++;
      if (core_out_tready[1] !== 1'b1) begin errors++; $display("FAIL reorder_core1_served: tready=%0b required 1", core_out_tready[1]); end
      @(posedge aclk); #1;
      core_out_tvalid[1] = 1'b0;
      core_out_tlast[1]  = 1'b0;
      checks++;
      if (out_tag_q.size() !== 3) begin errors++; $display("FAIL reorder_count: got %0d beats required 3", out_tag_q.size()); end
      for (int k = 0; k < 3; k++) begin
         logic [7:0] gt;
         logic       gl;
         gt = (k < out_tag_q.size()) ? out_tag_q[k] : 8'hXX;
         gl = (k < out_last_q.size()) ? out_last_q[k] : 1'bX;
         checks++;
         if (gt !== exp_tag[k] || gl !== exp_last[k]) begin
            errors++;
            $display("FAIL reorder_beat[%0d]: got tag %h last %0b required tag %h last %0b", k, gt, gl, exp_tag[k], exp_last[k]);
         end
      end
      checks++;
      if (err_size !== 1'b0) begin errors++; $display("FAIL reorder_err_size: got %0b required 0", err_size); end
   endtask

   task automatic test_size_check();
      do_reset();
      for (int k = 0; k < 3; k++) send_chunk(16'd4096, 16'd100, 2, 1'b0);
      core_send(0, 64, 64, 8'h00);
      checks++;
      if (err_size !== 1'b0) begin errors++; $display("FAIL size_exact: err_size=%0b required 0", err_size); end
      core_send(1, 63, 64, 8'h00);
      checks++;
      if (err_size !== 1'b1) begin errors++; $display("FAIL size_short: err_size=%0b required 1", err_size); end
      core_send(2, 64, 64, 8'h00);
      checks++;
      if (err_size !== 1'b1) begin errors++; $display("FAIL size_sticky: err_size=%0b required 1", err_size); end
   endtask

   task automatic test_backpressure();
      do_reset();
      o_data_tready = 1'b0;
      for (int k = 0; k < 8; k++) send_chunk(16'd64, 16'd100, 2, 1'b0);
      i_data_tdata       = '0;
      i_data_tdata[31:0] = {16'd64, 16'd100};
      i_data_tvalid      = 1'b1;
      repeat (3) @(posedge aclk);
      #1;
      checks++;
      if (i_data_tready !== 1'b0) begin errors++; $display("FAIL bp_full_block: i_data_tready=%0b required 0", i_data_tready); end
      o_data_tready = 1'b1;
      core_send(0, 1, 64, 8'h00);
      checks++;
      if (i_data_tready !== 1'b1) begin errors++; $display("FAIL bp_after_pop: i_data_tready=%0b required 1", i_data_tready); end
      @(posedge aclk); #1;
      i_data_tvalid = 1'b0;
      send_body(2, 1'b0);
      checks++;
      if (in_core_q.size() !== 9 || in_core_q[in_core_q.size()-1] !== 0) begin
         errors++;
         $display("FAIL bp_ninth_core: got %0d chunks, last core %0d required 9 chunks, core 0",
                  in_core_q.size(), (in_core_q.size() > 0) ? in_core_q[in_core_q.size()-1] : -1);
      end
   endtask

   task automatic test_zero_length();
      int hs_before;
      do_reset();
      send_chunk(16'd64, 16'd100, 2, 1'b0);
      checks++;
      if (err_zero !== 1'b0) begin errors++; $display("FAIL zero_pre: err_zero=%0b required 0", err_zero); end
      hs_before = in_hs_total;
      send_hdr(16'd0, 16'd0);
      checks++;
      if (err_zero !== 1'b1) begin errors++; $display("FAIL zero_flag: err_zero=%0b required 1", err_zero); end
      checks++;
      if (in_hs_total !== hs_before || core_in_tvalid !== '0) begin
         errors++;
         $display("FAIL zero_no_dispatch: beats %0d tvalid %b required %0d / 0000", in_hs_total, core_in_tvalid, hs_before);
      end
      send_chunk(16'd64, 16'd100, 2, 1'b0);
      checks++;
      if (in_core_q.size() !== 2 || in_core_q[1] !== 1) begin
         errors++;
         $display("FAIL zero_wr_ptr: got %0d chunks, last core %0d required 2 chunks, core 1",
                  in_core_q.size(), (in_core_q.size() > 0) ? in_core_q[in_core_q.size()-1] : -1);
      end
      core_send(0, 1, 64, 8'h20);
      core_send(1, 1, 64, 8'h30);
      checks++;
      if (err_size !== 1'b0 || out_tag_q.size() !== 2) begin
         errors++;
         $display("FAIL zero_no_push: err_size=%0b out beats %0d required 0 / 2", err_size, out_tag_q.size());
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      send_hdr(16'd192, 16'd150);
      i_data_tdata  = DB'(1);
      i_data_tvalid = 1'b1;
      #1;
      checks++;
      if (core_in_tvalid !== 4'b0001) begin errors++; $display("FAIL midrst_pre: core_in_tvalid=%b required 0001", core_in_tvalid); end
      aresetn = 1'b0;
      #1;
      checks++;
      if (core_in_tvalid !== '0 || i_data_tready !== 1'b0) begin
         errors++;
         $display("FAIL midrst_in_idle: core_in_tvalid=%b i_tready=%0b required 0000/0", core_in_tvalid, i_data_tready);
      end
      checks++;
      if (o_data_tvalid !== 1'b0 || core_out_tready !== '0) begin
         errors++;
         $display("FAIL midrst_out_idle: o_tvalid=%0b core_out_tready=%b required 0/0000", o_data_tvalid, core_out_tready);
      end
      repeat (2) @(posedge aclk);
      clear_inputs();
      @(negedge aclk);
      aresetn = 1'b1;
      clear_logs();
      @(posedge aclk); #1;
      send_chunk(16'd64, 16'd100, 2, 1'b0);
      checks++;
      if (in_core_q.size() !== 1 || in_core_q[0] !== 0) begin
         errors++;
         $display("FAIL midrst_core0: got %0d chunks, first core %0d required 1 chunk, core 0",
                  in_core_q.size(), (in_core_q.size() > 0) ? in_core_q[0] : -1);
      end
      core_send(0, 1, 64, 8'h40);
      checks++;
      if ({err_size, err_zero} !== 2'b00) begin errors++; $display("FAIL midrst_errs: got %b required 00", {err_size, err_zero}); end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_reorder();
      test_size_check();
      test_backpressure();
      test_zero_length();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
